// File: rtl/ex_stage_unit.sv
// Execute stage of the 5-stage MIPS pipeline.
// Computes ALU results and branch targets from the ID/EX fields.
// Runs a 32-iteration shift-add multiply for MUL.
// Registers everything into EX/MEM and stalls upstream while a multiply runs.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   flush                 turn the current EX instruction into a bubble; aborts a multiply
//   wb_in, m_in           WB / MEM control groups from ID/EX
//   alu_op, alu_src       ALU operation class and operand-B select
//   reg_dst               destination select (1 = rd_in, 0 = rt_in)
//   pc_in                 PC+4 of the instruction
//   read_data1_in/2_in    rs / rt register values
//   imm_in                sign-extended immediate; funct = imm_in[5:0]
//   rt_in, rd_in          register number fields
//   stall                 combinational; 1 = IF/ID and ID/EX must hold
//   wb_out .. dest_reg    EX/MEM pipeline register fields
module ex_stage_unit #(
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic [1:0]  wb_in,
  input  logic [2:0]  m_in,
  input  logic [1:0]  alu_op,
  input  logic        alu_src,
  input  logic        reg_dst,
  input  logic [31:0] pc_in,
  input  logic [31:0] read_data1_in,
  input  logic [31:0] read_data2_in,
  input  logic [31:0] imm_in,
  input  logic [4:0]  rt_in,
  input  logic [4:0]  rd_in,
  output logic        stall,
  output logic [1:0]  wb_out,
  output logic [2:0]  m_out,
  output logic [31:0] branch_target,
  output logic        zero,
  output logic [31:0] alu_result,
  output logic [31:0] write_data,
  output logic [4:0]  dest_reg
);

  // MUL_CYCLES must match DATA_W: one iteration per multiplier bit.
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = $clog2(MUL_CYCLES);

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;
  localparam logic [5:0] FUNCT_MUL = 6'h18;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_c;
  logic [DATA_W-1:0] bt_c;
  logic [4:0]        dest_c;
  logic [5:0]        funct;
  logic              is_mul;

  // FSM-generated enables for the datapath registers
  logic ld_ex;
  logic ld_bubble;
  logic ld_mul;
  logic start_mul;
  logic step_mul;

  // Multiply operands, accumulator and the instruction context saved at issue
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        wb_q;
  logic [2:0]        m_q;
  logic [4:0]        dest_q;
  logic [DATA_W-1:0] bt_q;
  logic [DATA_W-1:0] wd_q;

  // Operand select, destination select, branch target and single-cycle ALU
  always_comb begin
    op_b   = alu_src ? imm_in : read_data2_in;
    dest_c = reg_dst ? rd_in : rt_in;
    funct  = imm_in[5:0];
    is_mul = (alu_op == 2'b10) && (funct == FUNCT_MUL);
    bt_c   = pc_in + {imm_in[DATA_W-3:0], 2'b00};
    alu_c  = '0;
    case (alu_op)
      2'b01: alu_c = read_data1_in - op_b;
      2'b10: begin
        case (funct)
          FUNCT_ADD: alu_c = read_data1_in + op_b;
          FUNCT_SUB: alu_c = read_data1_in - op_b;
          FUNCT_AND: alu_c = read_data1_in & op_b;
          FUNCT_OR:  alu_c = read_data1_in | op_b;
          FUNCT_SLT: alu_c = ($signed(read_data1_in) < $signed(op_b)) ? DATA_W'(1) : '0;
          default:   alu_c = '0;
        endcase
      end
      default: alu_c = read_data1_in + op_b;  // 00 add, 11 reserved behaves as add
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, stall and datapath enables; flush wins over a new MUL
  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    ld_ex     = 1'b0;
    ld_bubble = 1'b0;
    ld_mul    = 1'b0;
    start_mul = 1'b0;
    step_mul  = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IDLE: begin
          if (flush) begin
            ld_bubble = 1'b1;
          end else if (is_mul) begin
            stall     = 1'b1;
            start_mul = 1'b1;
            ld_bubble = 1'b1;
            state_d   = S_BUSY;
          end else begin
            ld_ex = 1'b1;
          end
        end
        S_BUSY: begin
          if (flush) begin
            ld_bubble = 1'b1;
            state_d   = S_IDLE;
          end else begin
            stall     = 1'b1;
            step_mul  = 1'b1;
            ld_bubble = 1'b1;
            if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          if (flush) begin
            ld_bubble = 1'b1;
          end else begin
            ld_mul = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Multiply datapath and EX/MEM pipeline register
  always_ff @(posedge clock) begin
    if (reset) begin
      a_q           <= '0;
      b_q           <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      wb_q          <= '0;
      m_q           <= '0;
      dest_q        <= '0;
      bt_q          <= '0;
      wd_q          <= '0;
      wb_out        <= '0;
      m_out         <= '0;
      branch_target <= '0;
      zero          <= 1'b0;
      alu_result    <= '0;
      write_data    <= '0;
      dest_reg      <= '0;
    end else begin
      if (start_mul) begin
        a_q    <= read_data1_in;
        b_q    <= op_b;
        acc_q  <= '0;
        cnt_q  <= '0;
        wb_q   <= wb_in;
        m_q    <= m_in;
        dest_q <= dest_c;
        bt_q   <= bt_c;
        wd_q   <= read_data2_in;
      end
      // One multiplier bit per cycle: add the shifted multiplicand when set
      if (step_mul) begin
        if (b_q[cnt_q]) begin
          acc_q <= acc_q + (a_q << cnt_q);
        end
        cnt_q <= cnt_q + CNT_W'(1);
      end
      // Bubbles clear only the control groups; data fields hold
      if (ld_bubble) begin
        wb_out <= '0;
        m_out  <= '0;
      end
      if (ld_ex) begin
        wb_out        <= wb_in;
        m_out         <= m_in;
        branch_target <= bt_c;
        zero          <= (alu_c == '0);
        alu_result    <= alu_c;
        write_data    <= read_data2_in;
        dest_reg      <= dest_c;
      end
      if (ld_mul) begin
        wb_out        <= wb_q;
        m_out         <= m_q;
        branch_target <= bt_q;
        zero          <= (acc_q == '0);
        alu_result    <= acc_q;
        write_data    <= wd_q;
        dest_reg      <= dest_q;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_unit.sv
module tb_ex_stage_unit;

  logic        clock;
  logic        reset;
  logic        flush;
  logic [1:0]  wb_in;
  logic [2:0]  m_in;
  logic [1:0]  alu_op;
  logic        alu_src;
  logic        reg_dst;
  logic [31:0] pc_in;
  logic [31:0] read_data1_in;
  logic [31:0] read_data2_in;
  logic [31:0] imm_in;
  logic [4:0]  rt_in;
  logic [4:0]  rd_in;
  logic        stall;
  logic [1:0]  wb_out;
  logic [2:0]  m_out;
  logic [31:0] branch_target;
  logic        zero;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic [4:0]  dest_reg;

  ex_stage_unit #(.MUL_CYCLES(32)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .wb_in(wb_in), .m_in(m_in), .alu_op(alu_op), .alu_src(alu_src),
    .reg_dst(reg_dst), .pc_in(pc_in), .read_data1_in(read_data1_in),
    .read_data2_in(read_data2_in), .imm_in(imm_in), .rt_in(rt_in),
    .rd_in(rd_in), .stall(stall), .wb_out(wb_out), .m_out(m_out),
    .branch_target(branch_target), .zero(zero), .alu_result(alu_result),
    .write_data(write_data), .dest_reg(dest_reg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] alu;
    logic        zero;
    logic [4:0]  dest;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] bt;
    logic [31:0] wd;
    logic        ctl_only;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [1:0]  op;
    logic        src;
    logic        rdst;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic        fl;
    exp_t        e;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  vec_t vecs[13];

  function automatic vec_t mkv(logic [31:0] pc, logic [31:0] rd1, logic [31:0] rd2,
                               logic [31:0] imm, logic [4:0] rt, logic [4:0] rd,
                               logic [1:0] op, logic src, logic rdst, logic [1:0] wb,
                               logic [2:0] m, logic fl, logic [31:0] e_alu, logic e_zero,
                               logic [4:0] e_dest, logic [1:0] e_wb, logic [2:0] e_m,
                               logic [31:0] e_bt, logic [31:0] e_wd);
    vec_t v;
    v.pc = pc; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.rt = rt; v.rd = rd;
    v.op = op; v.src = src; v.rdst = rdst; v.wb = wb; v.m = m; v.fl = fl;
    v.e.alu = e_alu; v.e.zero = e_zero; v.e.dest = e_dest; v.e.wb = e_wb;
    v.e.m = e_m; v.e.bt = e_bt; v.e.wd = e_wd; v.e.ctl_only = fl;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic check_ex(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty got 1 expected 0", tag);
    end else begin
      e = exp_q.pop_front();
      cmp({tag, ".wb"}, 32'(wb_out), 32'(e.wb));
      cmp({tag, ".m"},  32'(m_out),  32'(e.m));
      if (!e.ctl_only) begin
        cmp({tag, ".alu"},  alu_result,      e.alu);
        cmp({tag, ".zero"}, 32'(zero),       32'(e.zero));
        cmp({tag, ".dest"}, 32'(dest_reg),   32'(e.dest));
        cmp({tag, ".bt"},   branch_target,   e.bt);
        cmp({tag, ".wd"},   write_data,      e.wd);
      end
    end
  endtask

  task automatic drive(input vec_t v);
    pc_in = v.pc; read_data1_in = v.rd1; read_data2_in = v.rd2; imm_in = v.imm;
    rt_in = v.rt; rd_in = v.rd; alu_op = v.op; alu_src = v.src; reg_dst = v.rdst;
    wb_in = v.wb; m_in = v.m; flush = v.fl;
  endtask

  // Single-cycle instruction: stall must stay low, result after one edge
  task automatic apply(input vec_t v, input string tag);
    @(negedge clock);
    drive(v);
    exp_q.push_back(v.e);
    #1;
    cmp({tag, ".stall"}, 32'(stall), 32'd0);
    @(posedge clock);
    #1;
    check_ex(tag);
  endtask

  function automatic vec_t mul_vec(logic [31:0] a, logic [31:0] b, logic [31:0] prod);
    return mkv(32'h400, a, b, 32'h18, 5'd1, 5'd4, 2'b10, 1'b0, 1'b1, 2'b10, 3'b010, 1'b0,
               prod, (prod == 32'd0), 5'd4, 2'b10, 3'b010, 32'h460, b);
  endfunction

  // Full multiply: 33 stalled cycles, bubbles, product on the 34th edge
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] prod, input string tag);
    vec_t v;
    int   stall_cnt;
    int   bub_bad;
    v = mul_vec(a, b, prod);
    stall_cnt = 0;
    bub_bad = 0;
    @(negedge clock);
    drive(v);
    exp_q.push_back(v.e);
    for (int e = 0; e < 34; e++) begin
      if (e > 0) @(negedge clock);
      #1;
      if (stall === 1'b1) stall_cnt++;
      @(posedge clock);
      #1;
      if (e < 33 && (wb_out !== 2'b00 || m_out !== 3'b000)) bub_bad++;
    end
    cmp({tag, ".stall_cycles"}, 32'(stall_cnt), 32'd33);
    cmp({tag, ".bubble_errs"}, 32'(bub_bad), 32'd0);
    check_ex(tag);
  endtask

  initial begin
    vecs[0]  = mkv(32'h0, 32'd5, 32'd7, 32'h20, 5'd3, 5'd9, 2'b10, 1'b0, 1'b1, 2'b11, 3'b000, 1'b0,
                   32'd12, 1'b0, 5'd9, 2'b11, 3'b000, 32'h80, 32'd7);
    vecs[1]  = mkv(32'h100, 32'h1234, 32'h1234, 32'd4, 5'd5, 5'd6, 2'b01, 1'b0, 1'b0, 2'b00, 3'b001, 1'b0,
                   32'd0, 1'b1, 5'd5, 2'b00, 3'b001, 32'h110, 32'h1234);
    vecs[2]  = mkv(32'h200, 32'h1000, 32'hDEAD, 32'hFFFFFFFC, 5'd8, 5'd2, 2'b00, 1'b1, 1'b0, 2'b11, 3'b100, 1'b0,
                   32'h0FFC, 1'b0, 5'd8, 2'b11, 3'b100, 32'h1F0, 32'hDEAD);
    vecs[3]  = mkv(32'h0, 32'd10, 32'd3, 32'h22, 5'd1, 5'd10, 2'b10, 1'b0, 1'b1, 2'b10, 3'b000, 1'b0,
                   32'd7, 1'b0, 5'd10, 2'b10, 3'b000, 32'h88, 32'd3);
    vecs[4]  = mkv(32'h0, 32'hF0F0, 32'hFF00, 32'h24, 5'd1, 5'd11, 2'b10, 1'b0, 1'b1, 2'b10, 3'b000, 1'b0,
                   32'hF000, 1'b0, 5'd11, 2'b10, 3'b000, 32'h90, 32'hFF00);
    vecs[5]  = mkv(32'h0, 32'hF0F0, 32'h0F0F, 32'h25, 5'd1, 5'd12, 2'b10, 1'b0, 1'b1, 2'b10, 3'b000, 1'b0,
                   32'hFFFF, 1'b0, 5'd12, 2'b10, 3'b000, 32'h94, 32'h0F0F);
    vecs[6]  = mkv(32'h0, 32'hFFFFFFFF, 32'd1, 32'h2A, 5'd1, 5'd13, 2'b10, 1'b0, 1'b1, 2'b10, 3'b000, 1'b0,
                   32'd1, 1'b0, 5'd13, 2'b10, 3'b000, 32'hA8, 32'd1);
    vecs[7]  = mkv(32'h0, 32'd5, 32'd3, 32'h2A, 5'd1, 5'd14, 2'b10, 1'b0, 1'b1, 2'b10, 3'b000, 1'b0,
                   32'd0, 1'b1, 5'd14, 2'b10, 3'b000, 32'hA8, 32'd3);
    vecs[8]  = mkv(32'h0, 32'd9, 32'd9, 32'h3F, 5'd1, 5'd15, 2'b10, 1'b0, 1'b1, 2'b01, 3'b010, 1'b0,
                   32'd0, 1'b1, 5'd15, 2'b01, 3'b010, 32'hFC, 32'd9);
    vecs[9]  = mkv(32'h0, 32'h7FFFFFFF, 32'd1, 32'h10, 5'd7, 5'd2, 2'b11, 1'b0, 1'b0, 2'b01, 3'b000, 1'b0,
                   32'h80000000, 1'b0, 5'd7, 2'b01, 3'b000, 32'h40, 32'd1);
    vecs[10] = mkv(32'h0, 32'd1, 32'd2, 32'h20, 5'd1, 5'd3, 2'b10, 1'b0, 1'b1, 2'b11, 3'b101, 1'b1,
                   32'd0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0);
    vecs[11] = mkv(32'h10, 32'd0, 32'h55, 32'd1, 5'd20, 5'd3, 2'b01, 1'b1, 1'b0, 2'b01, 3'b000, 1'b0,
                   32'hFFFFFFFF, 1'b0, 5'd20, 2'b01, 3'b000, 32'h14, 32'h55);
    // MUL with flush: flush wins, no stall, bubble
    vecs[12] = mkv(32'h0, 32'd6, 32'd7, 32'h18, 5'd1, 5'd4, 2'b10, 1'b0, 1'b1, 2'b11, 3'b111, 1'b1,
                   32'd0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0);

    reset = 1'b1;
    drive(vecs[0]);
    flush = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    cmp("reset.stall", 32'(stall), 32'd0);
    cmp("reset.alu", alu_result, 32'd0);
    cmp("reset.wb", 32'(wb_out), 32'd0);
    cmp("reset.m", 32'(m_out), 32'd0);
    cmp("reset.bt", branch_target, 32'd0);
    cmp("reset.zero", 32'(zero), 32'd0);
    cmp("reset.wd", write_data, 32'd0);
    cmp("reset.dest", 32'(dest_reg), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // MUL 3 * -1, followed immediately by add 1+1
    run_mul(32'd3, 32'hFFFFFFFF, 32'hFFFFFFFD, "mul3xm1");
    apply(mkv(32'h0, 32'd1, 32'd1, 32'h20, 5'd0, 5'd3, 2'b10, 1'b0, 1'b1, 2'b11, 3'b000, 1'b0,
              32'd2, 1'b0, 5'd3, 2'b11, 3'b000, 32'h80, 32'd1), "add_after_mul");

    // Back-to-back MULs; second product wraps to zero
    run_mul(32'd6, 32'd7, 32'd42, "mul_b2b_a");
    run_mul(32'h10000, 32'h10000, 32'd0, "mul_b2b_b");

    // Abort a MUL with flush while counter is 10
    begin
      int bub_bad;
      int bad42;
      bub_bad = 0;
      bad42 = 0;
      @(negedge clock);
      drive(mul_vec(32'd6, 32'd7, 32'd42));
      for (int e = 0; e < 11; e++) begin
        @(posedge clock);
        #1;
        if (wb_out !== 2'b00 || m_out !== 3'b000) bub_bad++;
      end
      @(negedge clock);
      flush = 1'b1;
      #1;
      cmp("abort.stall", 32'(stall), 32'd0);
      @(posedge clock);
      #1;
      cmp("abort.bubble_errs", 32'(bub_bad), 32'd0);
      cmp("abort.wb", 32'(wb_out), 32'd0);
      cmp("abort.m", 32'(m_out), 32'd0);
      apply(mkv(32'h0, 32'd2, 32'd3, 32'h20, 5'd0, 5'd17, 2'b10, 1'b0, 1'b1, 2'b11, 3'b000, 1'b0,
                32'd5, 1'b0, 5'd17, 2'b11, 3'b000, 32'h80, 32'd3), "add_after_abort");
      for (int c = 0; c < 40; c++) begin
        @(posedge clock);
        #1;
        if (alu_result === 32'd42 || stall !== 1'b0) bad42++;
      end
      cmp("abort.no_product", 32'(bad42), 32'd0);
    end

    // Reset during BUSY, then a clean 6*7
    @(negedge clock);
    drive(mul_vec(32'd6, 32'd7, 32'd42));
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    alu_op = 2'b00;
    #1;
    cmp("rst_busy.stall", 32'(stall), 32'd0);
    @(posedge clock);
    #1;
    cmp("rst_busy.alu", alu_result, 32'd0);
    cmp("rst_busy.wb", 32'(wb_out), 32'd0);
    cmp("rst_busy.m", 32'(m_out), 32'd0);
    cmp("rst_busy.dest", 32'(dest_reg), 32'd0);
    cmp("rst_busy.bt", branch_target, 32'd0);
    cmp("rst_busy.wd", write_data, 32'd0);
    cmp("rst_busy.zero", 32'(zero), 32'd0);
    reset = 1'b0;
    run_mul(32'd6, 32'd7, 32'd42, "mul_after_rst");

    cmp("scoreboard.left", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
